// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one single-ported memory, keeping one
// transaction outstanding at a time with fetch anti-starvation and a hang watchdog.
module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             err,
  output logic             busy
);

  localparam int SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t         state, state_nxt;
  logic [SW-1:0]  streak;
  logic [TW-1:0]  tcnt;
  logic           own_d;
  logic           cmd_we;
  logic [WIDTH-1:0] cmd_addr;
  logic [WIDTH-1:0] cmd_wdata;
  logic           pick_f, pick_d;
  logic           timeout;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    if (v == SW'(MAX_STREAK)) return v;
    return v + SW'(1);
  endfunction

  assign timeout = (state == S_WAIT) && (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    pick_f    = 1'b0;
    pick_d    = 1'b0;
    if (state == S_IDLE && !reset) begin
      // Data has priority unless fetch has been passed over MAX_STREAK times.
      if (d_req && !(if_req && streak == SW'(MAX_STREAK))) pick_d = 1'b1;
      else if (if_req)                                      pick_f = 1'b1;
    end
    if (state == S_IDLE) begin
      if (pick_f || pick_d) state_nxt = S_WAIT;
    end else if (mem_ack || timeout) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      streak    <= '0;
      tcnt      <= '0;
      own_d     <= 1'b0;
      cmd_we    <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      err       <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_nxt;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      err       <= 1'b0;
      if (pick_f) begin
        streak <= '0;
        tcnt   <= '0;
        own_d  <= 1'b0;
        cmd_we <= 1'b0;
      end
      if (pick_d) begin
        streak <= if_req ? sat_inc(streak) : '0;
        tcnt   <= '0;
        own_d  <= 1'b1;
        cmd_we <= d_we;
      end
      if (state == S_WAIT) begin
        tcnt <= tcnt + TW'(1);
        // An ack on the timeout edge wins: normal completion, no error.
        if (mem_ack || timeout) begin
          err <= !mem_ack;
          if (own_d) begin
            d_rvalid <= 1'b1;
            if (!cmd_we) d_rdata <= mem_ack ? mem_rdata : '0;
          end else begin
            if_rvalid <= 1'b1;
            if_rdata  <= mem_ack ? mem_rdata : '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pick_f) begin
      cmd_addr  <= if_addr;
      cmd_wdata <= '0;
    end else if (pick_d) begin
      cmd_addr  <= d_addr;
      cmd_wdata <= d_we ? d_wdata : '0;
    end
  end

  assign if_gnt    = pick_f;
  assign d_gnt     = pick_d;
  assign mem_req   = (state == S_WAIT);
  assign busy      = mem_req;
  assign mem_we    = mem_req && cmd_we;
  assign mem_addr  = mem_req ? cmd_addr : '0;
  assign mem_wdata = mem_req ? cmd_wdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Replaces the separate imem/dmem pair when the core is moved to a shared memory with variable, handshaked latency.
- Arbitrates with data priority plus an anti-starvation limit for fetch, sequences one outstanding memory transaction at a time, and returns completion pulses and read data to the owning requester.
- Includes a watchdog that aborts hung transactions.

Parameters:
WIDTH, 32, address and data width
MAX_STREAK, 4, consecutive data grants allowed while fetch is waiting before fetch is forced to win
TIMEOUT, 64, cycles in WAIT before abort; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch read request
if_addr  in  WIDTH  fetch address
if_gnt  out  1  fetch request accepted (1-cycle pulse)
if_rvalid  out  1  fetch data valid (1-cycle pulse)
if_rdata  out  WIDTH  fetch read data, held until next fetch completion
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_addr  in  WIDTH  data address
d_wdata  in  WIDTH  store data
d_gnt  out  1  data request accepted (1-cycle pulse)
d_rvalid  out  1  data completion pulse (loads and stores)
d_rdata  out  WIDTH  load data, held until next data completion
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  WIDTH  memory address
mem_wdata  out  WIDTH  memory write data
mem_ack  in  1  memory completion, sampled on rising edge
mem_rdata  in  WIDTH  memory read data, valid with mem_ack
err  out  1  watchdog abort pulse
busy  out  1  high in WAIT

Behaviour:
- Reset (asynchronous): state = IDLE; every output = 0; if_rdata = d_rdata = 0; streak = 0; timeout counter = 0. Reset asserted mid-transaction drops mem_req immediately. A mem_ack arriving after reset deasserts is ignored.
- FSM IDLE:
  - Winner is chosen combinationally. d_req alone wins data; if_req alone wins fetch.
  - Both requesting: data wins unless streak == MAX_STREAK, in which case fetch wins.
  - Winner's gnt is high in this cycle only. The command (owner, we, addr, wdata) is latched at the edge; next state = WAIT.
  - No request: stay IDLE, gnts = 0.
- Streak counter:
  - Fetch grant: set to 0.
  - Data grant with if_req high: increment, saturating at MAX_STREAK.
  - Data grant with if_req low: set to 0.
- FSM WAIT:
  - busy = 1; mem_req = 1 with the latched command; mem_we = 0 for fetch; mem_wdata = 0 for loads.
  - mem_ack = 1 at an edge: for a fetch or load, owner's rdata <= mem_rdata; owner's rvalid = 1 for the next cycle; next state = IDLE.
  - Minimum latency gnt -> rvalid is 2 cycles (ack in the first WAIT cycle).
  - The rvalid cycle coincides with IDLE, so the next grant may issue in that same cycle. Back-to-back throughput is one transaction per 2 cycles.
- Watchdog:
  - Counts WAIT cycles.
  - If the count reaches TIMEOUT (TIMEOUT != 0) without mem_ack: abort. Owner's rvalid pulses with owner's rdata = 0; err pulses 1 cycle (same cycle as rvalid); next state = IDLE.
  - mem_ack on the same edge as the timeout takes precedence: normal completion, no err.
- Protocol rules:
  - Requesters hold req and payload stable until gnt and may change them in the gnt cycle.
  - Arbiter ignores requests while in WAIT; gnt is never asserted in WAIT.
  - mem_ack while in IDLE is ignored.
  - Stores do not modify d_rdata.
  - At most one gnt and at most one rvalid per cycle.

Test Plan:
- Reset, then if_req=1, if_addr=0x10; memory acks after 3 WAIT cycles with 0x00500113 -> if_gnt in cycle 1; mem_req high 3 cycles with addr 0x10, we=0; if_rvalid with if_rdata=0x00500113; d_* outputs stay 0.
- d_req=1, d_we=1, addr 0x20, wdata 67727382; ack in 1 cycle -> mem_we=1, mem_wdata=67727382; d_rvalid pulses; d_rdata unchanged.
- if_req and d_req both held high continuously, ack every 1 cycle -> grant order D,D,D,D,F,D,D,D,D,F; streak returns to 0 after each fetch grant.
- Memory never acks, TIMEOUT=64 -> err and d_rvalid pulse together exactly 64 WAIT cycles after d_gnt; d_rdata=0; next cycle is IDLE and accepts a new request.
- Reset asserted in the 2nd WAIT cycle of a load -> mem_req falls without a clock edge; a later mem_ack produces no rvalid; streak=0.
- Timeout and mem_ack on the same edge, TIMEOUT=4, load data 0xDEADBEEF -> d_rvalid pulses with d_rdata=0xDEADBEEF; err stays 0.
